// File: rtl/mem_stage_lsu.sv
// Memory stage: runs loads/stores over a req/ack data port, forwards ALU results, flags faults.
// Latency: ALU op 1 cycle, load ack+1. Backpressure: ex_ready is low for the whole bus transaction.
module mem_stage_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        ex_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_misalign,
  output logic        exc_bus,
  output logic [31:0] exc_addr
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q, wdata_q, wb_data_q, exc_addr_q;
  logic [3:0]    be_q;
  logic [2:0]    f3_q;
  logic [4:0]    rd_q, wb_rd_q;
  logic          we_q, wb_valid_q, wb_we_q, exc_mis_q, exc_bus_q;

  logic          accept, is_mem, illegal, misal, go_busy, ack_fire, to_fire;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata, ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  always_comb begin
    is_mem   = ex_is_load | ex_is_store;
    illegal  = (ex_is_load & ex_is_store) |
               (ex_is_load & ((ex_funct3 == 3'b011) | (ex_funct3[2:1] == 2'b11))) |
               (ex_is_store & ex_funct3[2]);
    misal    = is_mem & (((ex_funct3[1:0] == 2'b01) & ex_addr[0]) |
                         ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00)));
    accept   = (state_q == IDLE) & ex_valid;
    go_busy  = accept & is_mem & ~illegal & ~misal;
    ack_fire = (state_q == BUSY) & dmem_ack;
    to_fire  = (state_q == BUSY) & ~dmem_ack & (cnt_q == CNT_LAST);
  end

  // Narrow stores replicate the datum on every lane so the enables alone pick the bytes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_wdata;
    if (ex_is_store) begin
      case (ex_funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << ex_addr[1:0];
          st_wdata = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{ex_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_busy) state_d = BUSY;
      BUSY:    if (ack_fire || to_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      exc_mis_q  <= 1'b0;
      exc_bus_q  <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      exc_mis_q  <= 1'b0;
      exc_bus_q  <= 1'b0;
      if (go_busy) cnt_q <= '0;
      else if (state_q == BUSY) cnt_q <= cnt_q + CW'(1);
      if (accept) begin
        if (illegal) begin
          exc_bus_q  <= 1'b1;
          exc_addr_q <= ex_addr;
        end else if (misal) begin
          exc_mis_q  <= 1'b1;
          exc_addr_q <= ex_addr;
        end else if (is_mem) begin
          addr_q  <= ex_addr;
          wdata_q <= st_wdata;
          be_q    <= st_be;
          we_q    <= ex_is_store;
          f3_q    <= ex_funct3;
          rd_q    <= ex_rd;
        end else begin
          wb_valid_q <= 1'b1;
          wb_we_q    <= (ex_rd != 5'd0);
          wb_rd_q    <= ex_rd;
          wb_data_q  <= ex_addr;
        end
      end
      if (ack_fire && !we_q) begin
        wb_valid_q <= 1'b1;
        wb_we_q    <= (rd_q != 5'd0);
        wb_rd_q    <= rd_q;
        wb_data_q  <= ld_data;
      end
      if (to_fire) begin
        exc_bus_q  <= 1'b1;
        exc_addr_q <= addr_q;
      end
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign dmem_req     = (state_q == BUSY);
  assign dmem_we      = we_q;
  assign dmem_addr    = {addr_q[31:2], 2'b00};
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign exc_misalign = exc_mis_q;
  assign exc_bus      = exc_bus_q;
  assign exc_addr     = exc_addr_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Random and directed stimulus for mem_stage_lsu, checked against a transaction-level model.
module tb_mem_stage_lsu;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_ready;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misalign, exc_bus;
  logic [31:0] exc_addr;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .ex_ready(ex_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misalign(exc_misalign), .exc_bus(exc_bus), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (rdata >> (8 * (addr % 4))) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  // k = BUSY cycle (1-based) in which ack is given; k > TMO means ack withheld.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int k, input logic [31:0] rdata);
    logic illegal, misal;
    int size;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    illegal = (ld && st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 >= 4);
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    misal = (ld || st) && (addr % size != 0);
    e_be = 4'hF;
    e_wd = wdata;
    if (st && size == 1) begin e_be = 4'(1 << (addr % 4)); e_wd = (wdata & 32'hFF) * 32'h0101_0101; end
    if (st && size == 2) begin e_be = (addr % 4 >= 2) ? 4'hC : 4'h3; e_wd = (wdata & 32'hFFFF) * 32'h0001_0001; end

    chk("ready_before", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (illegal || misal) begin
      chk("exc_bus", 32'(exc_bus), 32'(illegal));
      chk("exc_misalign", 32'(exc_misalign), 32'(!illegal));
      chk("exc_addr", exc_addr, addr);
      chk("exc_no_req", 32'(dmem_req), 32'd0);
      chk("exc_no_wb", 32'(wb_valid), 32'd0);
      chk("exc_ready", 32'(ex_ready), 32'd1);
    end else if (!ld && !st) begin
      chk("alu_wb_valid", 32'(wb_valid), 32'd1);
      chk("alu_wb_data", wb_data, addr);
      chk("alu_wb_rd", 32'(wb_rd), 32'(rd));
      chk("alu_wb_we", 32'(wb_we), 32'(rd != 0));
      chk("alu_no_req", 32'(dmem_req), 32'd0);
    end else begin
      for (int c = 1; c <= TMO; c++) begin
        chk("busy_req", 32'(dmem_req), 32'd1);
        chk("busy_ready", 32'(ex_ready), 32'd0);
        chk("busy_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("busy_be", 32'(dmem_be), 32'(e_be));
        chk("busy_we", 32'(dmem_we), 32'(st));
        if (st) chk("busy_wdata", dmem_wdata, e_wd);
        chk("busy_no_wb", 32'(wb_valid), 32'd0);
        if (c == k) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
        else dmem_rdata = $urandom;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        if (c == k) begin
          chk("done_req", 32'(dmem_req), 32'd0);
          chk("done_ready", 32'(ex_ready), 32'd1);
          chk("done_exc_bus", 32'(exc_bus), 32'd0);
          chk("done_wb_valid", 32'(wb_valid), 32'(ld));
          if (ld) begin
            chk("ld_wb_data", wb_data, model_load(f3, addr, rdata));
            chk("ld_wb_rd", 32'(wb_rd), 32'(rd));
            chk("ld_wb_we", 32'(wb_we), 32'(rd != 0));
          end
          break;
        end
        if (c == TMO) begin
          chk("tmo_req", 32'(dmem_req), 32'd0);
          chk("tmo_exc_bus", 32'(exc_bus), 32'd1);
          chk("tmo_exc_addr", exc_addr, addr);
          chk("tmo_no_wb", 32'(wb_valid), 32'd0);
          chk("tmo_ready", 32'(ex_ready), 32'd1);
        end
      end
    end
    @(posedge clk); #1;
    chk("pulse_wb_clear", 32'(wb_valid), 32'd0);
    chk("pulse_exc_clear", 32'(exc_bus | exc_misalign), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #10;
    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_exc", 32'({exc_bus, exc_misalign}), 32'd0);
    chk("rst_exc_addr", exc_addr, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_op(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 0, 32'd0);
    run_op(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 5'd0, 0, 32'd0);
    run_op(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 5'd7, 4, 32'h80AA_BBCC);
    run_op(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'd0, 5'd7, 4, 32'h80AA_BBCC);
    run_op(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 2, 32'd0);
    run_op(1'b1, 1'b0, 3'd2, 32'h0000_0301, 32'd0, 5'd3, 1, 32'd0);
    run_op(1'b1, 1'b0, 3'd3, 32'h0000_0400, 32'd0, 5'd3, 1, 32'd0);
    run_op(1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'd0, 5'd9, TMO + 1, 32'd0);
    run_op(1'b1, 1'b0, 3'd2, 32'h0000_0600, 32'd0, 5'd9, TMO, 32'h1234_5678);

    // Reset in the middle of a transaction, then a stray ack.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'd2;
    ex_addr = 32'h0000_0700; ex_rd = 5'd4;
    @(posedge clk); #1 ex_valid = 1'b0;
    chk("rstmid_req_before", 32'(dmem_req), 32'd1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("rstmid_req_async", 32'(dmem_req), 32'd0);
    chk("rstmid_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    dmem_ack = 1'b1;
    @(posedge clk); #1 dmem_ack = 1'b0;
    chk("stray_ack_no_wb", 32'(wb_valid), 32'd0);
    chk("stray_ack_ready", 32'(ex_ready), 32'd1);

    for (int i = 0; i < 300; i++) begin
      int r, kk;
      logic ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      logic [2:0] ld_codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      logic [2:0] st_codes [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd1, 3'd4};
      r  = $urandom_range(0, 9);
      ld = (r == 3 || r == 4 || r == 5 || r == 8);
      st = (r == 6 || r == 7 || r == 8);
      f3 = 3'($urandom_range(0, 7));
      if (ld) f3 = ld_codes[$urandom_range(0, 7)];
      else if (st) f3 = st_codes[$urandom_range(0, 5)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      kk = $urandom_range(1, TMO + 1);
      if ($urandom_range(0, 7) == 0) begin
        dmem_ack = 1'b1;
        @(posedge clk); #1 dmem_ack = 1'b0;
        chk("idle_ack_no_wb", 32'(wb_valid), 32'd0);
      end
      run_op(ld, st, f3, a, $urandom, 5'($urandom_range(0, 31)), kk, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
EX→WB memory stage of the 5-stage core, directly downstream of the ALU. Consumes the ALU result, which is either the effective address for loads/stores or the writeback value for ALU ops. Runs loads and stores over a req/ack data-memory port with byte-lane alignment and load sign/zero extension, stalling EX while busy. Flags misaligned, illegal and timed-out accesses, and delivers a registered writeback record.

Parameters:
TIMEOUT, 255, max BUSY cycles without dmem_ack before bus-error abort (≥1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ex_valid  in  1  EX presents an instruction
ex_is_load  in  1  instruction is a load
ex_is_store  in  1  instruction is a store
ex_funct3  in  3  RV32I width/sign code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101)
ex_addr  in  32  ALU result: address (mem ops) or writeback data (ALU ops)
ex_wdata  in  32  store data (rs2)
ex_rd  in  5  destination register
ex_ready  out  1  stage accepts an instruction this cycle
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, bits [1:0] = 0
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  request done; dmem_rdata valid this cycle
dmem_rdata  in  32  read word
wb_valid  out  1  writeback record valid (1-cycle pulse)
wb_we  out  1  write register file
wb_rd  out  5  destination
wb_data  out  32  result
exc_misalign  out  1  misaligned access (1-cycle pulse)
exc_bus  out  1  illegal encoding or timeout (1-cycle pulse)
exc_addr  out  32  faulting ex_addr, held until next exception

Behaviour:
- Reset (async): state IDLE, timeout counter 0. All outputs 0 except ex_ready = 1. dmem_req drops immediately, even mid-transaction; a later ack is ignored.
- States:
  - IDLE: ex_ready = 1. Accept when ex_valid = 1.
  - BUSY: ex_ready = 0, dmem_req = 1. dmem_we/addr/wdata/be stay stable until ack or abort.
- Accept in IDLE, decoded in priority order:
  - ex_is_load & ex_is_store both 1, load funct3 ∈ {011,110,111}, or store funct3[2] = 1 → exc_bus pulse next cycle, exc_addr = ex_addr, no request.
  - Misaligned (H: addr[0] = 1; W: addr[1:0] ≠ 0) → exc_misalign pulse next cycle, exc_addr = ex_addr, no request, stay IDLE.
  - Aligned load/store → capture fields, go BUSY; dmem_req rises the next cycle.
  - Neither load nor store (ALU op) → next cycle wb_valid = 1, wb_data = ex_addr, wb_rd = ex_rd, wb_we = (ex_rd ≠ 0).
- Store encoding, b = addr[1:0]:
  - SB: be = 0001 << b, wdata = {4{ex_wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{ex_wdata[15:0]}}.
  - SW: be = 1111, wdata = ex_wdata.
- Load encoding: be = 1111, dmem_we = 0.
- BUSY with dmem_ack = 1 → IDLE next cycle. For loads, the result is registered:
  - Lane = dmem_rdata >> 8·b (byte) or >> 16·addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - wb_valid pulses in the cycle after ack; wb_we = (rd ≠ 0).
  - Stores produce no wb_valid.
- Latency:
  - ALU op: 1 cycle.
  - Load: accept T, req from T+1, ack at Ta, wb_valid at Ta+1.
  - Minimum load-to-wb is 2 cycles (ack at T+1).
- Timeout: the counter increments on each BUSY cycle without ack. On the cycle it would reach TIMEOUT: drop dmem_req, exc_bus pulse, exc_addr = captured addr, return to IDLE, no wb. An ack in the same cycle wins over timeout. The counter clears on entering BUSY.
- dmem_ack in IDLE is ignored. ex_valid in BUSY is not accepted; EX must hold its inputs stable.
- Outputs are registered: wb_*, exc_* and dmem_* come from flops. ex_ready is decoded from state only.

Test Plan:
- ALU op: ex_addr = 0x0000_1234, rd = 5 → next cycle wb_valid = 1, wb_data = 0x1234, wb_we = 1. Same with rd = 0 → wb_we = 0.
- LB at 0x103, rdata = 0x80AA_BBCC, ack 3 cycles after req → wb_data = 0xFFFF_FF80, dmem_addr = 0x100, wb_valid exactly one cycle after ack. LBU at the same address → wb_data = 0x0000_0080.
- SH at 0x202, wdata = 0xDEAD_BEEF → dmem_addr = 0x200, be = 1100, dmem_wdata = 0xBEEF_BEEF, dmem_we = 1, no wb_valid, ex_ready low until the cycle after ack.
- LW at 0x301 → exc_misalign pulse, exc_addr = 0x301, dmem_req never rises. Load funct3 = 011 → exc_bus pulse.
- TIMEOUT = 4, ack withheld → dmem_req high 4 cycles, then low with exc_bus pulse. Ack arriving on the 4th cycle → normal completion, no exc_bus.
- rst asserted mid-BUSY → dmem_req low asynchronously, ex_ready = 1 after release. A stray ack afterwards produces no wb_valid.
